frame_ring_ctrl: RTL and testbench



---
 rtl/frame_ring_pkg.sv | 25 ++
 rtl/frame_ring_port.sv | 75 +++++++
 rtl/frame_ring_ctrl.sv | 169 ++++++++++++++++
 tb/tb_frame_ring_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/frame_ring_pkg.sv
// Shared types and helpers for the frame ring controller (optional FRAME_REPEAT_EN build
// behaviour lives in frame_ring_ctrl).
package frame_ring_pkg;

  typedef enum logic [1:0] {
    WrIdle,
    WrFill,
    WrWait
  } wr_state_e;

  typedef enum logic {
    RdIdle,
    RdRead
  } rd_state_e;

  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  // Base of the following slot: the next sequential word, or the ring base after the last slot.
  function automatic logic [63:0] wrap_addr(input logic [63:0] addr, input logic last_slot,
                                            input logic [63:0] base);
    return last_slot ? base : addr + 64'd1;
  endfunction

endpackage

// File: rtl/frame_ring_port.sv
// Slot/offset counter and word-address generator for one side of the frame ring.
// hold_i at the last accepted word rewinds to the current slot base instead of advancing.
module frame_ring_port
  import frame_ring_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 29,
  parameter int unsigned BASE_ADDR   = 2,
  parameter int unsigned FRAME_WORDS = 500,
  parameter int unsigned NUM_FRAMES  = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  accept_i,
  input  logic                  hold_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o,
  output logic                  done_o
);

  localparam int unsigned OffW  = $clog2(FRAME_WORDS);
  localparam int unsigned SlotW = $clog2(NUM_FRAMES);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [OffW-1:0]       off_q, off_d;
  logic [SlotW-1:0]      slot_q, slot_d;
  logic                  done_q, done_d;
  logic                  last_slot;

  assign last_o    = (off_q == OffW'(FRAME_WORDS - 1));
  assign last_slot = (slot_q == SlotW'(NUM_FRAMES - 1));
  assign addr_o    = addr_q;
  assign done_o    = done_q;

  always_comb begin
    addr_d = addr_q;
    base_d = base_q;
    off_d  = off_q;
    slot_d = slot_q;
    done_d = DEASSERT_H;
    if (accept_i) begin
      if (last_o) begin
        done_d = ASSERT_H;
        off_d  = '0;
        if (hold_i) begin
          addr_d = base_q;
        end else begin
          addr_d = ADDR_WIDTH'(wrap_addr(64'(addr_q), last_slot, 64'(BASE_ADDR)));
          base_d = addr_d;
          slot_d = last_slot ? '0 : slot_q + SlotW'(1);
        end
      end else begin
        off_d  = off_q + OffW'(1);
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q <= ADDR_WIDTH'(BASE_ADDR);
      base_q <= ADDR_WIDTH'(BASE_ADDR);
      off_q  <= '0;
      slot_q <= '0;
      done_q <= DEASSERT_H;
    end else begin
      addr_q <= addr_d;
      base_q <= base_d;
      off_q  <= off_d;
      slot_q <= slot_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/frame_ring_ctrl.sv
// Frame ring controller: whole-frame writes and in-order reads over NUM_FRAMES slots.
// Define FRAME_REPEAT_EN to make the reader hold and reread its last frame.
module frame_ring_ctrl
  import frame_ring_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 29,
  parameter int unsigned BASE_ADDR   = 2,
  parameter int unsigned FRAME_WORDS = 500,
  parameter int unsigned NUM_FRAMES  = 3,
  parameter int unsigned CNT_WIDTH   = 4
) (
  input  logic                  wr_clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic                  wr_rdy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  rd_req,
  input  logic                  rd_rdy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_frame_done,
  output logic                  rd_frame_done,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  full,
  output logic                  empty
);

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic wr_en_q, wr_en_d;
  logic rd_en_q, rd_en_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  logic wr_accept, rd_accept, wr_last, rd_last, rd_hold, commit, release_frame;

  assign wr_accept = wr_en_q & wr_rdy;
  assign rd_accept = rd_en_q & rd_rdy;
  assign commit    = wr_accept & wr_last;

`ifdef FRAME_REPEAT_EN
  // The frame on display stays held until a newer one is committed behind it.
  assign rd_hold = (frame_cnt_q < CNT_WIDTH'(2));
`else
  assign rd_hold = DEASSERT_H;
`endif

  assign release_frame = rd_accept & rd_last & ~rd_hold;

  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;
  assign frame_cnt = frame_cnt_q;
  assign full      = (frame_cnt_q == CNT_WIDTH'(NUM_FRAMES));
  assign empty     = (frame_cnt_q == '0);

  frame_ring_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .FRAME_WORDS(FRAME_WORDS),
    .NUM_FRAMES (NUM_FRAMES)
  ) u_wr_port (
    .clk_i   (wr_clk),
    .reset_i (reset),
    .accept_i(wr_accept),
    .hold_i  (DEASSERT_H),
    .addr_o  (wr_addr),
    .last_o  (wr_last),
    .done_o  (wr_frame_done)
  );

  frame_ring_port #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .FRAME_WORDS(FRAME_WORDS),
    .NUM_FRAMES (NUM_FRAMES)
  ) u_rd_port (
    .clk_i   (wr_clk),
    .reset_i (reset),
    .accept_i(rd_accept),
    .hold_i  (rd_hold),
    .addr_o  (rd_addr),
    .last_o  (rd_last),
    .done_o  (rd_frame_done)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    wr_en_d    = wr_en_q;
    case (wr_state_q)
      WrIdle: begin
        wr_en_d = DEASSERT_H;
        if (wr_req) begin
          if (!full) begin
            wr_state_d = WrFill;
            wr_en_d    = ASSERT_H;
          end else begin
            wr_state_d = WrWait;
          end
        end
      end
      WrFill: begin
        wr_en_d = wr_req;
        if (commit) begin
          wr_state_d = WrIdle;
          wr_en_d    = DEASSERT_H;
        end
      end
      WrWait: begin
        wr_en_d = DEASSERT_H;
        if (!full) wr_state_d = WrIdle;
      end
      default: begin
        wr_state_d = WrIdle;
        wr_en_d    = DEASSERT_H;
      end
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_en_d    = rd_en_q;
    case (rd_state_q)
      RdIdle: begin
        rd_en_d = DEASSERT_H;
        if (rd_req && !empty) begin
          rd_state_d = RdRead;
          rd_en_d    = ASSERT_H;
        end
      end
      RdRead: begin
        rd_en_d = rd_req;
        if (rd_accept && rd_last) begin
          rd_state_d = RdIdle;
          rd_en_d    = DEASSERT_H;
        end
      end
      default: begin
        rd_state_d = RdIdle;
        rd_en_d    = DEASSERT_H;
      end
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    case ({commit, release_frame})
      2'b10:   frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
      2'b01:   frame_cnt_d = frame_cnt_q - CNT_WIDTH'(1);
      default: frame_cnt_d = frame_cnt_q;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wr_state_q  <= WrIdle;
      rd_state_q  <= RdIdle;
      wr_en_q     <= DEASSERT_H;
      rd_en_q     <= DEASSERT_H;
      frame_cnt_q <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_frame_ring_ctrl.sv
// Self-checking bench for frame_ring_ctrl: directed steps plus randomized traffic
// against a frame/word-count model of the ring.
module tb_frame_ring_ctrl;

  localparam int unsigned AW   = 29;
  localparam int unsigned BASE = 2;
  localparam int unsigned FW   = 4;
  localparam int unsigned NF   = 3;
  localparam int unsigned CW   = 4;
`ifdef FRAME_REPEAT_EN
  localparam bit Repeat = 1'b1;
`else
  localparam bit Repeat = 1'b0;
`endif

  logic          wr_clk = 1'b0;
  logic          reset, wr_req, wr_rdy, rd_req, rd_rdy;
  logic          wr_en, rd_en, wr_frame_done, rd_frame_done, full, empty;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [CW-1:0] frame_cnt;

  int tests = 0;
  int fails = 0;

  // Model: frames committed/released so far, offsets inside the current frames,
  // handshake phase of each side (0 idle, 1 transferring, 2 waiting for space).
  int m_wf, m_woff, m_rel, m_roff;
  int m_wph, m_rph;
  int m_wen, m_ren, m_wdone, m_rdone;

  frame_ring_ctrl #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FW),
    .NUM_FRAMES (NF),
    .CNT_WIDTH  (CW)
  ) dut (
    .wr_clk       (wr_clk),
    .reset        (reset),
    .wr_req       (wr_req),
    .wr_rdy       (wr_rdy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_req       (rd_req),
    .rd_rdy       (rd_rdy),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .wr_frame_done(wr_frame_done),
    .rd_frame_done(rd_frame_done),
    .frame_cnt    (frame_cnt),
    .full         (full),
    .empty        (empty)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int cnt;
    cnt = m_wf - m_rel;
    check("wr_en", int'(wr_en), m_wen);
    check("rd_en", int'(rd_en), m_ren);
    check("wr_addr", int'(wr_addr), BASE + (m_wf % NF) * FW + m_woff);
    check("rd_addr", int'(rd_addr), BASE + (m_rel % NF) * FW + m_roff);
    check("wr_frame_done", int'(wr_frame_done), m_wdone);
    check("rd_frame_done", int'(rd_frame_done), m_rdone);
    check("frame_cnt", int'(frame_cnt), cnt);
    check("full", int'(full), int'(cnt == NF));
    check("empty", int'(empty), int'(cnt == 0));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit wq, input bit wy, input bit rq, input bit ry, input bit rs);
    int  cnt;
    bit  is_full, is_empty, wacc, racc, commit, rlast, rel;
    reset  = rs;
    wr_req = wq;
    wr_rdy = wy;
    rd_req = rq;
    rd_rdy = ry;
    if (rs) begin
      m_wf = 0; m_woff = 0; m_rel = 0; m_roff = 0;
      m_wph = 0; m_rph = 0; m_wen = 0; m_ren = 0; m_wdone = 0; m_rdone = 0;
    end else begin
      cnt      = m_wf - m_rel;
      is_full  = (cnt == NF);
      is_empty = (cnt == 0);
      wacc     = (m_wen == 1) && wy;
      racc     = (m_ren == 1) && ry;
      commit   = wacc && (m_woff == FW - 1);
      rlast    = racc && (m_roff == FW - 1);
      rel      = rlast && (!Repeat || cnt >= 2);
      case (m_wph)
        0: begin
          m_wen = 0;
          if (wq) begin
            if (!is_full) begin m_wph = 1; m_wen = 1; end
            else m_wph = 2;
          end
        end
        1: begin
          m_wen = int'(wq);
          if (commit) begin m_wph = 0; m_wen = 0; end
        end
        default: begin
          m_wen = 0;
          if (!is_full) m_wph = 0;
        end
      endcase
      if (m_rph == 0) begin
        m_ren = 0;
        if (rq && !is_empty) begin m_rph = 1; m_ren = 1; end
      end else begin
        m_ren = int'(rq);
        if (rlast) begin m_rph = 0; m_ren = 0; end
      end
      m_woff  = commit ? 0 : m_woff + int'(wacc);
      m_wf    = m_wf + int'(commit);
      m_roff  = rlast ? 0 : m_roff + int'(racc);
      m_rel   = m_rel + int'(rel);
      m_wdone = int'(commit);
      m_rdone = int'(rlast);
    end
    @(posedge wr_clk);
    #1;
    check_all();
  endtask

  initial begin
    bit seen;
    int wb, rb;

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_wr_addr", int'(wr_addr), 2);
    check("reset_empty", int'(empty), 1);

    // Three full frames with no reader: the ring fills and the writer parks.
    repeat (24) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fill_full", int'(full), 1);
    check("fill_wr_en", int'(wr_en), 0);
    check("fill_cnt", int'(frame_cnt), 3);

    // Drain one frame; the writer must then resume at slot 0.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      if (rd_frame_done) seen = 1'b1;
    end
    check("drain_done_seen", int'(seen), 1);
    check("drain_not_full", int'(full), 0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stuttering write-ready while reading.
    for (int i = 0; i < 40; i++) step(1'b1, i[0], 1'b1, (i % 3) != 0, 1'b0);

    // Reset in the middle of a frame.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_frame_addr", int'(wr_addr), 4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_mid_wr_addr", int'(wr_addr), 2);
    check("rst_mid_cnt", int'(frame_cnt), 0);
    check("rst_mid_wr_en", int'(wr_en), 0);
    check("rst_mid_rd_en", int'(rd_en), 0);

    // Randomized traffic in blocks with different write/read pressure.
    for (int b = 0; b < 4; b++) begin
      wb = (b % 2 == 0) ? 85 : 45;
      rb = (b % 2 == 0) ? 45 : 85;
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 99) < wb, $urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < rb, $urandom_range(0, 99) < 70,
             $urandom_range(0, 299) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
